// File: rtl/rv_fetch_pkg.sv
// Shared widths and the instruction-length rule for the fetch/align stage.
package rv_fetch_pkg;

  localparam int unsigned HW_W   = 16;
  localparam int unsigned INST_W = 32;
  localparam logic [1:0]  RVC_OPC_MASK = 2'b11;

  function automatic logic is_rvc(input logic [HW_W-1:0] hw);
    return (hw[1:0] & RVC_OPC_MASK) != RVC_OPC_MASK;
  endfunction

endpackage

// File: rtl/fetch_hq.sv
// Halfword queue: single push, pop of 0/1/2 entries, flush; exposes the two head entries.
module fetch_hq
  import rv_fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [HW_W-1:0]  push_data,
  input  logic [1:0]       pop,
  output logic [HW_W-1:0]  hw0,
  output logic [HW_W-1:0]  hw1,
  output logic [CNT_W-1:0] count
);

  logic [HW_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr_nx;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    rd_ptr_nx = rd_ptr_q + PTR_W'(1);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush && !reset) mem_q[wr_ptr_q] <= push_data;
  end

  assign hw0   = mem_q[rd_ptr_q];
  assign hw1   = mem_q[rd_ptr_nx];
  assign count = count_q;

endmodule

// File: rtl/ifetch_align.sv
// Instruction fetch/align: issues halfword reads, queues returns, emits aligned instructions.
// Define IFETCH_RVC_EN for a mixed 16/32-bit stream; otherwise every instruction is 32-bit.
module ifetch_align
  import rv_fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned HQ_DEPTH   = 4,
  parameter logic [31:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [HW_W-1:0]       mem_dout,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_W-1:0]     inst,
  output logic [31:0]           inst_pc,
  output logic                  inst_rvc
);

  localparam int unsigned CNT_W = $clog2(HQ_DEPTH) + 1;
`ifdef IFETCH_RVC_EN
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFE;
  localparam logic        RVC_EN  = 1'b1;
`else
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;
  localparam logic        RVC_EN  = 1'b0;
`endif

  logic [31:0]      fetch_pc_q, fetch_pc_d, head_pc_q, head_pc_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] count;
  logic [HW_W-1:0]  hw0, hw1;
  logic             head_rvc, enough, xfer, push;
  logic [1:0]       pop_n;
  logic [CNT_W:0]   occ_after;
  logic [31:0]      tgt_pc, issue_pc, head_step;

  fetch_hq #(.DEPTH(HQ_DEPTH)) u_hq (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect),
    .push     (push),
    .push_data(mem_dout),
    .pop      (pop_n),
    .hw0      (hw0),
    .hw1      (hw1),
    .count    (count)
  );

  always_comb begin
    tgt_pc     = redirect_pc & PC_MASK;
    head_rvc   = RVC_EN && is_rvc(hw0);
    enough     = head_rvc ? (count >= CNT_W'(1)) : (count >= CNT_W'(2));
    inst_valid = enough && !redirect && !reset;
    xfer       = inst_valid && inst_ready;
    pop_n      = xfer ? (head_rvc ? 2'd1 : 2'd2) : 2'd0;
    // A returning read only lands if no redirect kills it this cycle.
    push       = inflight_q && !redirect;
    // Occupancy once this cycle's pop and the returning read are both accounted for.
    occ_after  = redirect ? '0
               : ((CNT_W+1)'(count) - (CNT_W+1)'(pop_n) + (CNT_W+1)'(inflight_q));
    mem_en     = !reset && (occ_after < (CNT_W+1)'(HQ_DEPTH));
    issue_pc   = redirect ? tgt_pc : fetch_pc_q;
    mem_addr   = issue_pc[ADDR_WIDTH:1];
    fetch_pc_d = issue_pc + {29'd0, mem_en, 2'b00} / 32'd2;
    inflight_d = mem_en;
    head_step  = xfer ? (head_rvc ? 32'd2 : 32'd4) : '0;
    head_pc_d  = redirect ? tgt_pc : head_pc_q + head_step;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      head_pc_q  <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
      inflight_q <= inflight_d;
    end
  end

  assign inst     = head_rvc ? {16'h0000, hw0} : {hw1, hw0};
  assign inst_pc  = head_pc_q;
  assign inst_rvc = head_rvc;

endmodule

// File: tb/tb_ifetch_align.sv
// Randomized bench for ifetch_align against an instruction-stream reference model.
module tb_ifetch_align;

  localparam int unsigned AW = 13;
  localparam int unsigned N  = 1 << AW;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef IFETCH_RVC_EN
  localparam logic        RVC_EN  = 1'b1;
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFE;
`else
  localparam logic        RVC_EN  = 1'b0;
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_dout = '0;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [31:0]   inst;
  logic [31:0]   inst_pc;
  logic          inst_rvc;

  logic [15:0] bram [N];

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_fetch;
  int          since;
  logic        first_pend;
  logic        prev_hold;

  ifetch_align #(.ADDR_WIDTH(AW), .HQ_DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_dout   (mem_dout),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_rvc   (inst_rvc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) mem_dout <= bram[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // The instruction that starts at byte PC pc, from the program image.
  function automatic void model(input logic [31:0] pc, output logic [31:0] ei, output logic er);
    logic [AW-1:0] a0, a1;
    logic [15:0]   h0, h1;
    a0 = pc[AW:1];
    a1 = a0 + 1'b1;
    h0 = bram[a0];
    h1 = bram[a1];
    er = RVC_EN && (h0[1:0] != 2'b11);
    ei = er ? {16'h0000, h0} : {h1, h0};
  endfunction

  task automatic cycle(input logic rst_i, input logic rd_i, input logic [31:0] tgt_i,
                       input logic rdy_i);
    logic [31:0] ei;
    logic        er;
    int          need;
    @(negedge clk);
    reset = rst_i; redirect = rd_i; redirect_pc = tgt_i; inst_ready = rdy_i;
    #1;
    if (rst_i) begin
      check("rst_mem_en", {31'd0, mem_en}, 32'd0);
      check("rst_valid", {31'd0, inst_valid}, 32'd0);
      exp_pc = RESET_PC; exp_fetch = RESET_PC >> 1;
      since = -1; first_pend = 1'b1; prev_hold = 1'b0;
    end else begin
      since++;
      if (rd_i) begin
        exp_pc = tgt_i & PC_MASK; exp_fetch = exp_pc >> 1;
        since = 0; first_pend = 1'b1; prev_hold = 1'b0;
        check("redir_valid", {31'd0, inst_valid}, 32'd0);
      end
      if (since == 0) check("issue_after_flush", {31'd0, mem_en}, 32'd1);
      if (prev_hold) check("hold_valid", {31'd0, inst_valid}, 32'd1);
      model(exp_pc, ei, er);
      need = er ? 1 : 2;
      if (first_pend && since <= need)
        check("early_valid", {31'd0, inst_valid}, 32'd0);
      else if (first_pend && since == need + 1)
        check("latency_valid", {31'd0, inst_valid}, 32'd1);
      if (mem_en) begin
        check("mem_addr", {{(32-AW){1'b0}}, mem_addr}, {{(32-AW){1'b0}}, exp_fetch[AW-1:0]});
        exp_fetch = exp_fetch + 1;
      end
      if (inst_valid) begin
        check("inst", inst, ei);
        check("inst_pc", inst_pc, exp_pc);
        check("inst_rvc", {31'd0, inst_rvc}, {31'd0, er});
        first_pend = 1'b0;
        if (rdy_i) exp_pc = exp_pc + (er ? 32'd2 : 32'd4);
      end
      prev_hold = inst_valid && !rdy_i;
    end
  endtask

  initial begin
    exp_pc = RESET_PC; exp_fetch = '0; since = -1; first_pend = 1'b1; prev_hold = 1'b0;
    for (int unsigned i = 0; i < N; i++) bram[i] = 16'($urandom);
    bram[0] = 16'h0001; bram[1] = 16'h4501; bram[2] = 16'h0513; bram[3] = 16'h0000;

    // two RVC then addi a0,x0,0
    repeat (2) cycle(1'b1, 1'b0, '0, 1'b1);
    repeat (8) cycle(1'b0, 1'b0, '0, 1'b1);

    // stall until the queue fills, then drain without loss
    repeat (10) cycle(1'b0, 1'b0, '0, 1'b0);
    check("stall_full_mem_en", {31'd0, mem_en}, 32'd0);
    repeat (10) cycle(1'b0, 1'b0, '0, 1'b1);

    // redirect with a read in flight and a partly filled queue
    repeat (3) cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b1, 32'h0000_0106, 1'b1);
    repeat (8) cycle(1'b0, 1'b0, '0, 1'b1);

    // instruction stream crossing the address wrap
    bram[N-2] = 16'h0001; bram[N-1] = 16'h0513; bram[0] = 16'h1234; bram[1] = 16'h0002;
    repeat (2) cycle(1'b1, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b1, (N - 2) * 2, 1'b1);
    repeat (8) cycle(1'b0, 1'b0, '0, 1'b1);

    // reset right after an issue: the returning read must be dropped
    cycle(1'b0, 1'b1, 32'h0000_0040, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b1);
    repeat (8) cycle(1'b0, 1'b0, '0, 1'b1);

    // back-to-back redirects
    cycle(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    cycle(1'b0, 1'b1, 32'h0000_0A0A, 1'b1);
    repeat (6) cycle(1'b0, 1'b0, '0, 1'b1);

    // random traffic over a fresh random image
    for (int unsigned i = 0; i < N; i++) bram[i] = 16'($urandom);
    repeat (2) cycle(1'b1, 1'b0, '0, 1'b1);
    for (int unsigned n = 0; n < 4000; n++)
      cycle(($urandom % 64) == 0, ($urandom % 16) == 0, $urandom, ($urandom % 4) != 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
